// File: rtl/tile_ram_arbiter_pkg.sv
// ============================================================================
//  Module   : tile_ram_arbiter_pkg
//  Brief    : Shared encodings and widths for the tile RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_ram_arbiter_pkg;

    localparam int C_ADDR_W = 10;
    localparam int C_DATA_W = 8;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_RELOAD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_GM   = 2'd2
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/tile_ram_arbiter_if.sv
// ============================================================================
//  Module   : tile_ram_arbiter_if
//  Brief    : Requester and RAM-side signals of the tile RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_ram_arbiter_if
    import tile_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic              vid_miss;
    logic [DATA_W-1:0] vid_data;

    logic              ini_req;
    logic [ADDR_W-1:0] ini_addr;
    logic [DATA_W-1:0] ini_wdata;
    logic              ini_done;
    logic              ini_gnt;
    logic              reload_req;

    logic              gm_req;
    logic              gm_we;
    logic [ADDR_W-1:0] gm_addr;
    logic [DATA_W-1:0] gm_wdata;
    logic              gm_gnt;
    logic              gm_rvalid;
    logic [DATA_W-1:0] gm_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    logic              ready;

    modport master (
        output vid_req, vid_addr, ini_req, ini_addr, ini_wdata, ini_done,
               reload_req, gm_req, gm_we, gm_addr, gm_wdata, ram_dout,
        input  vid_valid, vid_miss, vid_data, ini_gnt, gm_gnt, gm_rvalid,
               gm_rdata, ram_addr, ram_din, ram_we, ready
    );

    modport slave (
        input  vid_req, vid_addr, ini_req, ini_addr, ini_wdata, ini_done,
               reload_req, gm_req, gm_we, gm_addr, gm_wdata, ram_dout,
        output vid_valid, vid_miss, vid_data, ini_gnt, gm_gnt, gm_rvalid,
               gm_rdata, ram_addr, ram_din, ram_we, ready
    );

endinterface

`default_nettype wire

// File: rtl/tile_ram_arbiter_readtag.sv
// ============================================================================
//  Module   : tile_ram_readtag
//  Brief    : Remembers who owned last cycle's read and steers RAM data back.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_ram_readtag
    import tile_ram_arbiter_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire tag_t              i_tag_nxt,
    input  wire logic [DATA_W-1:0] i_ram_dout,
    output logic                   o_vid_valid,
    output logic [DATA_W-1:0]      o_vid_data,
    output logic                   o_gm_rvalid,
    output logic [DATA_W-1:0]      o_gm_rdata
);

    tag_t r_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= TAG_NONE;
        end else begin
            r_tag <= i_tag_nxt;
        end
    end

    // Data is zeroed when not valid so idle returns never leak stale RAM output.
    always_comb begin
        o_vid_valid = (r_tag == TAG_VID);
        o_gm_rvalid = (r_tag == TAG_GM);
        o_vid_data  = o_vid_valid ? i_ram_dout : '0;
        o_gm_rdata  = o_gm_rvalid ? i_ram_dout : '0;
    end

endmodule

`default_nettype wire

// File: rtl/tile_ram_arbiter.sv
// ============================================================================
//  Module   : tile_ram_arbiter
//  Brief    : Shares the tile RAM port between video, map init and game logic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_ram_arbiter
    import tile_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = C_ADDR_W,
    parameter int DATA_W   = C_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  wire logic         clk,
    input  wire logic         reset,
    tile_ram_arbiter_if.slave bus
);

    localparam int C_WAIT_W = $clog2(MAX_WAIT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_WAIT_W-1:0]   r_wait_cnt;
    logic                  r_vid_miss;
    logic                  w_run;
    logic                  w_gm_pri;
    logic                  w_vid_gnt;
    logic                  w_ini_gnt;
    logic                  w_gm_gnt;
    tag_t                  w_tag_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT, S_RELOAD: if (bus.ini_done)   w_state_nxt = S_RUN;
            S_RUN:            if (bus.reload_req) w_state_nxt = S_RELOAD;
            default:          w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        w_run     = (r_state == S_RUN);
        bus.ready = w_run;
    end

    // A game requester that has waited MAX_WAIT cycles steals exactly one slot.
    assign w_gm_pri = (r_wait_cnt == C_WAIT_W'(MAX_WAIT));

    always_comb begin
        w_vid_gnt = 1'b0;
        w_ini_gnt = 1'b0;
        w_gm_gnt  = 1'b0;
        if (!reset) begin
            if (w_run) begin
                if (w_gm_pri && bus.gm_req) begin
                    w_gm_gnt = 1'b1;
                end else if (bus.vid_req) begin
                    w_vid_gnt = 1'b1;
                end else if (bus.gm_req) begin
                    w_gm_gnt = 1'b1;
                end
            end else begin
                if (bus.vid_req) begin
                    w_vid_gnt = 1'b1;
                end else if (bus.ini_req) begin
                    w_ini_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        bus.ram_we   = 1'b0;
        if (w_ini_gnt) begin
            bus.ram_addr = bus.ini_addr;
            bus.ram_din  = bus.ini_wdata;
            bus.ram_we   = 1'b1;
        end else if (w_gm_gnt) begin
            bus.ram_addr = bus.gm_addr;
            bus.ram_din  = bus.gm_wdata;
            bus.ram_we   = bus.gm_we;
        end else if (w_vid_gnt) begin
            bus.ram_addr = bus.vid_addr;
        end
    end

    always_comb begin
        w_tag_nxt = TAG_NONE;
        if (w_vid_gnt) begin
            w_tag_nxt = TAG_VID;
        end else if (w_gm_gnt && !bus.gm_we) begin
            w_tag_nxt = TAG_GM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_run || w_gm_gnt) begin
            r_wait_cnt <= '0;
        end else if (bus.gm_req && !w_gm_pri) begin
            r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vid_miss <= 1'b0;
        end else begin
            r_vid_miss <= bus.vid_req && !w_vid_gnt;
        end
    end

    assign bus.vid_miss = r_vid_miss;
    assign bus.ini_gnt  = w_ini_gnt;
    assign bus.gm_gnt   = w_gm_gnt;

    tile_ram_readtag #(
        .DATA_W (DATA_W)
    ) u_readtag (
        .clk         (clk),
        .reset       (reset),
        .i_tag_nxt   (w_tag_nxt),
        .i_ram_dout  (bus.ram_dout),
        .o_vid_valid (bus.vid_valid),
        .o_vid_data  (bus.vid_data),
        .o_gm_rvalid (bus.gm_rvalid),
        .o_gm_rdata  (bus.gm_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_tile_ram_arbiter.sv
// ============================================================================
//  Module   : tb_tile_ram_arbiter
//  Brief    : Directed bench with a read-return scoreboard for the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_ram_arbiter;
    import tile_ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tile_ram_arbiter_if bus ();

    tile_ram_arbiter #(
        .ADDR_W   (10),
        .DATA_W   (8),
        .MAX_WAIT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] ram_mem [1024];
    logic [7:0] exp_mem [1024];

    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    typedef struct {
        logic       is_gm;
        logic [7:0] data;
    } ret_t;
    ret_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fill(input int a);
        return (a == 'h021) ? 8'h05 : (8'(a) ^ 8'hA5);
    endfunction

    task automatic settle();
        #1;
    endtask

    // Called just after inputs settle; crosses one rising edge and ends on the falling edge.
    task automatic tick();
        logic vg;
        logic em;
        ret_t r;
        vg = bus.vid_req && !reset && !bus.gm_gnt;
        em = bus.vid_req && !vg && !reset;
        if (vg) begin
            sb.push_back('{1'b0, exp_mem[bus.vid_addr]});
            chk("vid_ram_addr", 32'(bus.ram_addr), 32'(bus.vid_addr));
            chk("vid_ram_we", 32'(bus.ram_we), 0);
        end
        if (bus.gm_gnt && !bus.gm_we) sb.push_back('{1'b1, exp_mem[bus.gm_addr]});
        if (bus.gm_gnt && bus.gm_we) exp_mem[bus.gm_addr] = bus.gm_wdata;
        if (bus.ini_gnt) exp_mem[bus.ini_addr] = bus.ini_wdata;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("vid_valid", 32'(bus.vid_valid), 32'(!r.is_gm));
            chk("gm_rvalid", 32'(bus.gm_rvalid), 32'(r.is_gm));
            if (r.is_gm) chk("gm_rdata", 32'(bus.gm_rdata), 32'(r.data));
            else         chk("vid_data", 32'(bus.vid_data), 32'(r.data));
        end else begin
            chk("vid_valid_idle", 32'(bus.vid_valid), 0);
            chk("gm_rvalid_idle", 32'(bus.gm_rvalid), 0);
        end
        chk("vid_miss", 32'(bus.vid_miss), 32'(em));
        @(negedge clk);
    endtask

    task automatic starve(input string tag, input logic [9:0] addr);
        int got;
        got = -1;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h100;
        bus.gm_req   = 1'b1;
        bus.gm_we    = 1'b0;
        bus.gm_addr  = addr;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (bus.gm_gnt) begin
                got = i;
                chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'(addr));
                tick();
                break;
            end
            tick();
        end
        chk({tag, "_gnt_cycle"}, got, 15);
        bus.gm_req = 1'b0;
        settle();
        tick();
        bus.vid_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.ini_req   = 1'b0;
        bus.ini_addr  = '0;
        bus.ini_wdata = '0;
        bus.ini_done  = 1'b0;
        bus.reload_req = 1'b0;
        bus.gm_req    = 1'b0;
        bus.gm_we     = 1'b0;
        bus.gm_addr   = '0;
        bus.gm_wdata  = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset overrides a pending write request.
        bus.ini_req = 1'b1;
        settle();
        chk("rst_ini_gnt", 32'(bus.ini_gnt), 0);
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        tick();
        reset = 1'b0;
        bus.ini_req = 1'b0;
        settle();
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_vid_valid", 32'(bus.vid_valid), 0);
        chk("rst_vid_miss", 32'(bus.vid_miss), 0);
        chk("rst_gm_rvalid", 32'(bus.gm_rvalid), 0);
        chk("rst_vid_data", 32'(bus.vid_data), 0);
        chk("rst_gm_rdata", 32'(bus.gm_rdata), 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_ram_we2", 32'(bus.ram_we), 0);

        // Full map fill; the game requests writes for the first 50 cycles.
        for (int a = 0; a < 1024; a++) begin
            bus.ini_req   = 1'b1;
            bus.ini_addr  = 10'(a);
            bus.ini_wdata = fill(a);
            bus.ini_done  = (a == 1023);
            bus.gm_req    = (a < 50);
            bus.gm_we     = 1'b1;
            bus.gm_addr   = 10'h003;
            bus.gm_wdata  = 8'hEE;
            settle();
            chk("fill_ini_gnt", 32'(bus.ini_gnt), 1);
            chk("fill_ram_we", 32'(bus.ram_we), 1);
            chk("fill_ram_addr", 32'(bus.ram_addr), a);
            chk("fill_ready", 32'(bus.ready), 0);
            if (a < 50) chk("init_gm_gnt", 32'(bus.gm_gnt), 0);
            tick();
        end
        bus.ini_req  = 1'b0;
        bus.ini_done = 1'b0;
        bus.gm_req   = 1'b0;
        settle();
        chk("run_ready", 32'(bus.ready), 1);

        // ini_done and ini_req have no effect while running.
        bus.ini_done = 1'b1;
        bus.ini_req  = 1'b1;
        settle();
        chk("run_ini_gnt", 32'(bus.ini_gnt), 0);
        chk("run_ini_we", 32'(bus.ram_we), 0);
        tick();
        bus.ini_done = 1'b0;
        bus.ini_req  = 1'b0;
        settle();
        chk("run_ready_hold", 32'(bus.ready), 1);

        starve("starve1", 10'h021);

        // Game write in blanking, then video reads it back; top address too.
        bus.gm_req   = 1'b1;
        bus.gm_we    = 1'b1;
        bus.gm_addr  = 10'h042;
        bus.gm_wdata = 8'h07;
        settle();
        chk("wr_gm_gnt", 32'(bus.gm_gnt), 1);
        chk("wr_ram_we", 32'(bus.ram_we), 1);
        chk("wr_ram_addr", 32'(bus.ram_addr), 32'h042);
        chk("wr_ram_din", 32'(bus.ram_din), 32'h07);
        tick();
        bus.gm_req   = 1'b0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h042;
        settle();
        tick();
        bus.vid_addr = 10'h3FF;
        settle();
        tick();
        bus.vid_req = 1'b0;
        settle();
        tick();

        // Reload requested alongside a game read.
        bus.gm_req     = 1'b1;
        bus.gm_we      = 1'b0;
        bus.gm_addr    = 10'h021;
        bus.reload_req = 1'b1;
        settle();
        chk("rl_gm_gnt", 32'(bus.gm_gnt), 1);
        tick();
        bus.reload_req = 1'b0;
        settle();
        chk("rl_ready", 32'(bus.ready), 0);
        for (int i = 0; i < 5; i++) begin
            chk("rl_gm_blocked", 32'(bus.gm_gnt), 0);
            tick();
            settle();
        end
        bus.gm_req    = 1'b0;
        bus.ini_req   = 1'b1;
        bus.ini_addr  = 10'h042;
        bus.ini_wdata = 8'h09;
        bus.vid_req   = 1'b1;
        bus.vid_addr  = 10'h010;
        settle();
        chk("rl_vid_over_ini", 32'(bus.ini_gnt), 0);
        tick();
        bus.vid_req = 1'b0;
        settle();
        chk("rl_ini_gnt", 32'(bus.ini_gnt), 1);
        tick();
        bus.ini_req = 1'b0;

        // Reset in the middle of the reload.
        reset = 1'b1;
        bus.vid_req = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        bus.vid_req = 1'b0;
        settle();
        chk("rst2_ready", 32'(bus.ready), 0);
        chk("rst2_vid_miss", 32'(bus.vid_miss), 0);
        chk("rst2_ram_we", 32'(bus.ram_we), 0);
        bus.ini_done = 1'b1;
        tick();
        bus.ini_done = 1'b0;
        settle();
        chk("rst2_run_ready", 32'(bus.ready), 1);

        starve("starve2", 10'h042);

        settle();
        tick();
        settle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tile_ram_arbiter.md
Name: tile_ram_arbiter

Overview:
- Owns the single port of the 32x32-byte tile RAM (RAM_sync, 10-bit address, 8-bit data, 1-cycle read latency).
- Shares that port between three requesters: the video tile fetch, the map initialiser (MapCellsEval), and game logic (pellet eat / ghost house updates).
- Sequences the boot/reload phases so game logic never touches the RAM while the map is being (re)written.
- Drives the `init`/ready signal that the top level uses to switch the RAM address source.

Parameters:
- ADDR_W, 10, RAM address width ({row,col}).
- DATA_W, 8, RAM data width.
- MAX_WAIT, 15, game-port wait cycles before it pre-empts video for one slot.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  video wants a read this cycle (active tile region)
- vid_addr  in  ADDR_W  video read address
- vid_valid  out  1  vid_data valid (1 cycle after grant)
- vid_miss  out  1  video slot was pre-empted; display renders blank
- vid_data  out  DATA_W  read data to tileMap
- ini_req  in  1  initialiser write request
- ini_addr  in  ADDR_W  initialiser address
- ini_wdata  in  DATA_W  initialiser data
- ini_done  in  1  pulse: last map cell written
- ini_gnt  out  1  initialiser write accepted this cycle
- reload_req  in  1  pulse: request map rewrite (new level)
- gm_req  in  1  game access request
- gm_we  in  1  1=write, 0=read
- gm_addr  in  ADDR_W  game address
- gm_wdata  in  DATA_W  game write data
- gm_gnt  out  1  game access accepted this cycle
- gm_rvalid  out  1  gm_rdata valid
- gm_rdata  out  DATA_W  game read data
- ram_addr  out  ADDR_W  to RAM_sync addr
- ram_din  out  DATA_W  to RAM_sync din
- ram_we  out  1  to RAM_sync we
- ram_dout  in  DATA_W  from RAM_sync dout
- ready  out  1  1 in S_RUN only

Behaviour:
- FSM states: S_INIT (reset state), S_RUN, S_RELOAD.
  - S_INIT -> S_RUN on ini_done.
  - S_RUN -> S_RELOAD on reload_req.
  - S_RELOAD -> S_RUN on ini_done.
  - reload_req is ignored outside S_RUN; ini_done is ignored in S_RUN.
- Grant logic: exactly one grant per cycle, combinational from registered state plus requests.
  - S_INIT / S_RELOAD: priority video > init. Game is never granted.
  - S_RUN: priority video > game. If wait_cnt == MAX_WAIT, priority becomes game > video for that cycle only. ini_req is ignored.
- Handshake: requesters hold req/addr/data stable until their gnt is high. A grant means the access is issued on the RAM port in that same cycle.
- ram_addr, ram_din and ram_we are muxed from the granted requester. ram_we = (ini_gnt) | (gm_gnt & gm_we).
  - With no grant: ram_we=0, ram_addr=0, ram_din=0.
- Read return: a 2-bit tag is registered each cycle (VID, GM, NONE).
  - Next cycle with tag VID: vid_valid=1, vid_data=ram_dout.
  - Next cycle with tag GM: gm_rvalid=1, gm_rdata=ram_dout.
  - Write grants produce no rvalid.
- vid_miss: registered. Asserts the cycle after vid_req was high and not granted. Never coincides with vid_valid.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments while gm_req & ~gm_gnt in S_RUN, saturating at MAX_WAIT.
  - Clears on gm_gnt or when not in S_RUN.
- Reset values: state=S_INIT, ready=0, tag=NONE, wait_cnt=0. All outputs 0 (vid_valid, vid_miss, gm_rvalid, data outputs, grants, ram_we). Reset dominates every other input in the same cycle.
- Simultaneous events:
  - ini_done in the same cycle as ini_gnt: the write completes and the state changes next cycle.
  - reload_req with gm_req in S_RUN: the game is still granted that cycle. From the next cycle the FSM is in S_RELOAD and the game is blocked.
  - A game read issued before S_RELOAD still returns its gm_rvalid.
- Address wrap: none. Addresses are passed through unmodified; 0x3FF is valid.

Decomposition:
- Shared package: state encoding (S_INIT=0, S_RUN=1, S_RELOAD=2), tag encoding (NONE=0, VID=1, GM=2), ADDR_W/DATA_W constants.
- One natural sub-module, tile_ram_readtag: tag register plus return demux for vid/gm valid/data. Everything else stays flat.

Test Plan:
- Reset then ini_req held with addr 0x000..0x3FF, vid_req=0:
  - 1024 consecutive ini_gnt, ram_we=1 each cycle.
  - ini_done on the last one -> ready=1 the next cycle.
- S_INIT, gm_req=1 held for 50 cycles -> gm_gnt stays 0 and ram_we only follows ini_gnt.
- S_RUN, vid_req=1 continuously, gm_req read addr 0x021 (RAM holds 0x05):
  - gm_gnt on the 16th waiting cycle (wait_cnt hits 15).
  - gm_rvalid=1, gm_rdata=0x05 the next cycle.
  - vid_miss=1 in that same cycle.
- S_RUN, vid_req and gm_req write (0x042 <- 0x07) in blanking (vid_req=0) -> gm_gnt same cycle, ram_we=1, ram_addr=0x042, ram_din=0x07. A video read of 0x042 later returns 0x07.
- S_RUN, reload_req with gm_req read in the same cycle -> game granted. The next cycle is S_RELOAD, ready=0, gm_rvalid=1, and further gm_req are not granted until ini_done.
- Mid-S_RELOAD reset pulse -> state=S_INIT, all outputs 0, wait_cnt=0 the next cycle.
